// File: rtl/bsg_mem_1r1w_sync_mask_write_byte_coalescer.sv
// bsg_mem_1r1w_sync_mask_write_byte_coalescer: single-entry write-combining buffer in front of a byte-masked 1r1w sync RAM
module bsg_mem_1r1w_sync_mask_write_byte_coalescer #(
  parameter int width_p       = 32,
  parameter int els_p         = 16,
  parameter int timeout_p     = 16,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int mask_width_lp = width_p >> 3
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  output logic                     ready_and_o,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [mask_width_lp-1:0] mask_i,
  input  logic                     flush_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic                     r_v_o,
  output logic [width_p-1:0]       r_data_o,
  output logic                     empty_o,
  output logic                     mem_w_v_o,
  output logic [mask_width_lp-1:0] mem_w_mask_o,
  output logic [addr_width_lp-1:0] mem_w_addr_o,
  output logic [width_p-1:0]       mem_w_data_o,
  output logic                     mem_r_v_o,
  output logic [addr_width_lp-1:0] mem_r_addr_o,
  input  logic [width_p-1:0]       mem_r_data_i
);
  localparam int tw_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [tw_lp-1:0] timer_max_lp = tw_lp'(timeout_p - 1);
  typedef enum logic {EMPTY, HOLD} state_e;
  state_e state_r, state_n;
  logic [addr_width_lp-1:0] buf_addr, addr_n;
  logic [width_p-1:0] buf_data, data_n, m_data, fwd_data, r_data_q, rd_merge;
  logic [mask_width_lp-1:0] buf_mask, mask_n, m_mask, fwd_mask;
  logic [tw_lp-1:0] timer_r, timer_n;
  logic hold, same, collide, wr, merge, flush_want, do_flush;
  assign hold = state_r == HOLD;
  assign same = hold && addr_i == buf_addr;
  assign collide = hold && r_v_i && r_addr_i == buf_addr;
  // a deferred flush can only block a write that would need to evict the entry
  assign ready_and_o = !(collide && addr_i != buf_addr);
  assign wr = v_i && ready_and_o && |mask_i;
  assign merge = wr && same;
  assign flush_want = hold && ((wr && !same) || flush_i || timer_r == timer_max_lp || (&buf_mask && !merge));
  assign do_flush = flush_want && !collide;
  assign m_mask = buf_mask | (merge ? mask_i : '0);
  always_comb begin
    m_data = buf_data;
    rd_merge = mem_r_data_i;
    for (int i = 0; i < mask_width_lp; i++) begin
      if (merge && mask_i[i]) m_data[8*i+:8] = data_i[8*i+:8];
      if (fwd_mask[i]) rd_merge[8*i+:8] = fwd_data[8*i+:8];
    end
  end
  always_comb begin
    state_n = state_r;
    addr_n = buf_addr;
    data_n = m_data;
    mask_n = m_mask;
    timer_n = (hold && timer_r != timer_max_lp) ? timer_r + tw_lp'(1) : timer_r;
    if (wr && !same) begin
      state_n = HOLD;
      addr_n = addr_i;
      data_n = data_i;
      mask_n = mask_i;
      timer_n = '0;
    end else if (do_flush) begin
      state_n = EMPTY;
      timer_n = '0;
    end else if (merge) timer_n = '0;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= EMPTY;
      buf_addr <= '0;
      buf_data <= '0;
      buf_mask <= '0;
      timer_r <= '0;
      r_v_o <= 1'b0;
      fwd_mask <= '0;
      fwd_data <= '0;
      r_data_q <= '0;
    end else begin
      state_r <= state_n;
      buf_addr <= addr_n;
      buf_data <= data_n;
      buf_mask <= mask_n;
      timer_r <= timer_n;
      r_v_o <= r_v_i;
      if (r_v_i) begin
        fwd_mask <= (hold && buf_addr == r_addr_i) ? buf_mask : '0;
        fwd_data <= buf_data;
      end
      if (r_v_o) r_data_q <= rd_merge;
    end
  assign r_data_o = r_v_o ? rd_merge : r_data_q;
  assign empty_o = !hold;
  assign mem_w_v_o = do_flush;
  assign mem_w_addr_o = buf_addr;
  assign mem_w_mask_o = m_mask;
  assign mem_w_data_o = m_data;
  assign mem_r_v_o = r_v_i;
  assign mem_r_addr_o = r_addr_i;
endmodule

// File: tb/tb_bsg_mem_1r1w_sync_mask_write_byte_coalescer.sv
// tb_bsg_mem_1r1w_sync_mask_write_byte_coalescer: directed bench with a byte-masked RAM model behind the coalescer
module tb_bsg_mem_1r1w_sync_mask_write_byte_coalescer;
  logic clk = 1'b0;
  logic reset_n, v, ready, flush, r_v, r_v_o, empty, wv, rv;
  logic [3:0] addr, r_addr, mask, wmask, waddr, raddr;
  logic [31:0] data, r_data, wdata, mem_rdata;
  logic [31:0] ram [16];
  int total = 0, bad = 0, wcount = 0, wc0;
  logic early;
  always #5 clk = ~clk;
  bsg_mem_1r1w_sync_mask_write_byte_coalescer #(.width_p(32), .els_p(16), .timeout_p(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .ready_and_o(ready), .addr_i(addr), .data_i(data),
    .mask_i(mask), .flush_i(flush), .r_v_i(r_v), .r_addr_i(r_addr), .r_v_o(r_v_o), .r_data_o(r_data),
    .empty_o(empty), .mem_w_v_o(wv), .mem_w_mask_o(wmask), .mem_w_addr_o(waddr), .mem_w_data_o(wdata),
    .mem_r_v_o(rv), .mem_r_addr_o(raddr), .mem_r_data_i(mem_rdata)
  );
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    ram[9] = 32'h11223344;
  end
  always @(posedge clk) begin
    if (wv) begin
      wcount <= wcount + 1;
      for (int k = 0; k < 4; k++) if (wmask[k]) ram[waddr][8*k+:8] <= wdata[8*k+:8];
    end
    if (rv) mem_rdata <= ram[raddr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    v = 1'b1; addr = a; data = d; mask = m;
  endtask
  initial begin
    reset_n = 1'b0; v = 1'b0; addr = '0; data = '0; mask = '0; flush = 1'b0; r_v = 1'b0; r_addr = '0;
    #2;
    chk("rst_empty", 32'(empty), 1); chk("rst_ready", 32'(ready), 1);
    chk("rst_wv", 32'(wv), 0); chk("rst_rv", 32'(r_v_o), 0); chk("rst_rdata", r_data, 0);
    @(negedge clk); reset_n = 1'b1;
    // coalesce two partial writes, flushed on timeout
    @(negedge clk); wc0 = wcount; wr(5, 32'h000000AA, 4'b0001);
    @(negedge clk); chk("t1_hold", 32'(empty), 0); wr(5, 32'h00CC0000, 4'b0100);
    @(negedge clk); v = 1'b0; early = 1'b0;
    for (int i = 0; i < 15; i++) begin #1; if (wv) early = 1'b1; @(negedge clk); end
    #1;
    chk("t1_early", 32'(early), 0); chk("t1_wv", 32'(wv), 1); chk("t1_waddr", 32'(waddr), 5);
    chk("t1_wmask", 32'(wmask), 32'h5); chk("t1_wdata", wdata & 32'h00FF00FF, 32'h00CC00AA);
    @(negedge clk);
    chk("t1_empty", 32'(empty), 1); chk("t1_ram", ram[5], 32'h00CC00AA); chk("t1_count", 32'(wcount - wc0), 1);
    // full mask flushes without waiting, then a new entry is held
    wr(3, 32'h00001122, 4'b0011);
    @(negedge clk); wr(3, 32'h33440000, 4'b1100);
    @(negedge clk); v = 1'b0; #1;
    chk("t2_wv", 32'(wv), 1); chk("t2_waddr", 32'(waddr), 3); chk("t2_wmask", 32'(wmask), 32'hF);
    chk("t2_wdata", wdata, 32'h33441122);
    @(negedge clk); chk("t2_empty", 32'(empty), 1); chk("t2_ram", ram[3], 32'h33441122);
    wr(7, 32'h00000055, 4'b0001);
    @(negedge clk); v = 1'b0; #1; chk("t2_bheld", 32'(empty), 0); chk("t2_bnowr", 32'(wv), 0);
    flush = 1'b1; #1; chk("t2_bflush", 32'(wv), 1); chk("t2_baddr", 32'(waddr), 7);
    @(negedge clk); flush = 1'b0; chk("t2_bempty", 32'(empty), 1); chk("t2_bram", ram[7], 32'h00000055);
    // read forwarding of a pending byte over RAM data
    wr(9, 32'hAABBCCDD, 4'b0010);
    @(negedge clk); v = 1'b0; r_v = 1'b1; r_addr = 9;
    @(negedge clk); r_v = 1'b0; chk("t3_rv", 32'(r_v_o), 1); chk("t3_rdata", r_data, 32'h1122CC44);
    @(negedge clk); chk("t3_rv_low", 32'(r_v_o), 0); chk("t3_rhold", r_data, 32'h1122CC44);
    flush = 1'b1; #1; chk("t3_wmask", 32'(wmask), 32'h2);
    @(negedge clk); flush = 1'b0; chk("t3_ram", ram[9], 32'h1122CC44);
    // flush deferred by a colliding read; different-address write stalls
    wr(2, 32'h00000077, 4'b0001);
    @(negedge clk); wr(6, 32'h00000099, 4'b0001); flush = 1'b1; r_v = 1'b1; r_addr = 2; #1;
    chk("t4_nowr", 32'(wv), 0); chk("t4_stall", 32'(ready), 0);
    @(negedge clk); r_v = 1'b0; #1;
    chk("t4_rv", 32'(r_v_o), 1); chk("t4_rdata", r_data, 32'h00000077);
    chk("t4_wv", 32'(wv), 1); chk("t4_waddr", 32'(waddr), 2); chk("t4_ready", 32'(ready), 1);
    @(negedge clk); v = 1'b0; flush = 1'b0;
    chk("t4_newhold", 32'(empty), 0); chk("t4_ram", ram[2], 32'h00000077);
    flush = 1'b1; #1; chk("t4_wv2", 32'(wv), 1); chk("t4_waddr2", 32'(waddr), 6);
    @(negedge clk); flush = 1'b0; chk("t4_empty", 32'(empty), 1); chk("t4_ram2", ram[6], 32'h00000099);
    // same-cycle read sees the buffer before the merge
    wr(4, 32'h000000A1, 4'b0001);
    @(negedge clk); wr(4, 32'h0000B200, 4'b0010); r_v = 1'b1; r_addr = 4;
    @(negedge clk); v = 1'b0; r_v = 1'b0; chk("t5_rdata", r_data, 32'h000000A1);
    flush = 1'b1; #1; chk("t5_wmask", 32'(wmask), 32'h3); chk("t5_wdata", wdata & 32'h0000FFFF, 32'h0000B2A1);
    @(negedge clk); flush = 1'b0;
    // reset drops the pending entry without a RAM write
    wr(8, 32'h000000C3, 4'b0001);
    @(negedge clk); v = 1'b0; r_v = 1'b1; r_addr = 8;
    @(negedge clk); r_v = 1'b0; chk("t6_rv", 32'(r_v_o), 1);
    wc0 = wcount; reset_n = 1'b0; #1;
    chk("t6_empty", 32'(empty), 1); chk("t6_rv_rst", 32'(r_v_o), 0); chk("t6_ready", 32'(ready), 1);
    @(negedge clk); reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_nowr", 32'(wcount - wc0), 0); chk("t6_still_empty", 32'(empty), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
